// File: rtl/rv32ima_pkg.sv
// Shared RV32 types for the multiply/divide unit: operand words, register tags,
// op encodings and FSM states.
package rv32ima_pkg;

  localparam int unsigned WORD_W       = 32;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned MULDIV_ITERS = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0]  reg_t;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } muldiv_state_t;

  // Divide-family op (quotient or remainder).
  function automatic logic is_div(input muldiv_op_t op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  // rs1 is interpreted as two's complement.
  function automatic logic a_signed(input muldiv_op_t op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  // rs2 is interpreted as two's complement.
  function automatic logic b_signed(input muldiv_op_t op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit with valid/ready on both sides.
// Optional build macro MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle
// combinational multiply captured at accept; divides stay iterative.
module muldiv_unit
  import rv32ima_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN)
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       flush,
  input  logic       in_valid,
  output logic       in_ready,
  input  muldiv_op_t in_op,
  input  word_t      in_a,
  input  word_t      in_b,
  input  reg_t       in_rd,
  output logic       out_valid,
  input  logic       out_ready,
  output word_t      out_result,
  output reg_t       out_rd
);

  muldiv_state_t     state_q, state_d;
  muldiv_op_t        op_q, op_d;
  logic              neg_q, neg_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   md_q, md_d;
  word_t             res_q, res_d;
  reg_t              rd_q, rd_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_top;
  logic [XLEN:0]     div_diff;
  logic              div_ge;
  logic [2*XLEN-1:0] step_nx;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  word_t             fin_res;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  word_t             fast_res;
`endif

  // One shift-add / restoring-subtract step plus the sign-corrected final result.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, md_q} : '0);
    div_top  = acc_q[2*XLEN-1:XLEN-1];
    div_ge   = (div_top >= {1'b0, md_q});
    div_diff = div_top - {1'b0, md_q};
    if (is_div(op_q)) begin
      step_nx = div_ge ? {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1}
                       : {div_top[XLEN-1:0],  acc_q[XLEN-2:0], 1'b0};
    end else begin
      step_nx = {mul_sum, acc_q[XLEN-1:1]};
    end
    prod_fix = neg_q ? -step_nx : step_nx;
    quot_fix = neg_q ? -step_nx[XLEN-1:0] : step_nx[XLEN-1:0];
    rem_fix  = neg_q ? -step_nx[2*XLEN-1:XLEN] : step_nx[2*XLEN-1:XLEN];
    case (op_q)
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fin_res = quot_fix;
      OP_REM, OP_REMU:              fin_res = rem_fix;
      default:                      fin_res = prod_fix[XLEN-1:0];
    endcase
  end

  // Operand magnitudes at accept; signed ops work on |a| and |b|.
  always_comb begin
    a_neg = a_signed(in_op) & in_a[XLEN-1];
    b_neg = b_signed(in_op) & in_b[XLEN-1];
    a_mag = a_neg ? -in_a : in_a;
    b_mag = b_neg ? -in_b : in_b;
  end

`ifdef MULDIV_FAST_MUL_EN
  // Single-cycle product of the sign/zero-extended operands.
  always_comb begin
    fast_a    = a_signed(in_op) ? {{XLEN{in_a[XLEN-1]}}, in_a} : {{XLEN{1'b0}}, in_a};
    fast_b    = b_signed(in_op) ? {{XLEN{in_b[XLEN-1]}}, in_b} : {{XLEN{1'b0}}, in_b};
    fast_prod = fast_a * fast_b;
    fast_res  = (in_op == OP_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
  end
`endif

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    md_d    = md_q;
    res_d   = res_q;
    rd_d    = rd_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          op_d  = in_op;
          rd_d  = in_rd;
          neg_d = (in_op inside {OP_REM, OP_REMU}) ? a_neg : (a_neg ^ b_neg);
          cnt_d = CNT_W'(XLEN - 1);
          acc_d = {{XLEN{1'b0}}, a_mag};
          md_d  = b_mag;
          if (is_div(in_op) && (in_b == '0)) begin
            res_d   = (in_op inside {OP_DIV, OP_DIVU}) ? '1 : in_a;
            state_d = ST_DONE;
          end else if ((in_op inside {OP_DIV, OP_REM}) &&
                       (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == '1)) begin
            res_d   = (in_op == OP_DIV) ? in_a : '0;
            state_d = ST_DONE;
`ifdef MULDIV_FAST_MUL_EN
          end else if (!is_div(in_op)) begin
            res_d   = fast_res;
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        acc_d = step_nx;
        if (cnt_q == '0) begin
          res_d   = fin_res;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      md_q        <= '0;
      res_q       <= '0;
      rd_q        <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      neg_q       <= neg_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      md_q        <= md_d;
      res_q       <= res_d;
      rd_q        <= rd_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_result = res_q;
  assign out_rd     = rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
  import rv32ima_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  localparam int DIV_LAT = 33;

  logic       clk;
  logic       nrst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  muldiv_op_t in_op;
  word_t      in_a;
  word_t      in_b;
  reg_t       in_rd;
  logic       out_valid;
  logic       out_ready;
  word_t      out_result;
  reg_t       out_rd;

  int tests;
  int fails;

  muldiv_unit dut (
    .clk        (clk),
    .nrst       (nrst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_rd      (in_rd),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_rd     (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one op, wait (bounded) for out_valid, check result, tag and latency.
  task automatic run_op(input string tag, input muldiv_op_t op, input word_t a, input word_t b,
                        input reg_t rd, input word_t exp, input int exp_lat);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_rd = rd;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_res"}, out_result, exp);
    check({tag, "_rd"}, 32'(out_rd), 32'(rd));
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
  endtask

  // With out_ready high the result is consumed on the next edge.
  task automatic drain(input string tag);
    @(posedge clk); #1;
    check({tag, "_ovld_clr"}, 32'(out_valid), 32'd0);
    check({tag, "_irdy_set"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int rose;
    tests = 0; fails = 0;
    nrst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = OP_MUL;
    in_a = '0; in_b = '0; in_rd = '0; out_ready = 1'b1;
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", 32'(out_rd), 32'd0);
    @(negedge clk); nrst = 1'b1;

    run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, MUL_LAT);
    drain("mul");
    run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, MUL_LAT);
    drain("mulhu");
    run_op("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, MUL_LAT);
    drain("mulh");
    run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFF, MUL_LAT);
    drain("mulhsu");
    run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 5'd9, 32'hFFFF_FFFD, DIV_LAT);
    drain("div");
    run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFF, DIV_LAT);
    drain("rem");
    run_op("divu", OP_DIVU, 32'd100, 32'd7, 5'd11, 32'd14, DIV_LAT);
    drain("divu");
    run_op("remu", OP_REMU, 32'd100, 32'd7, 5'd12, 32'd2, DIV_LAT);
    drain("remu");
    run_op("div0", OP_DIV, 32'd1234, 32'd0, 5'd13, 32'hFFFF_FFFF, 1);
    drain("div0");
    run_op("remu0", OP_REMU, 32'd5, 32'd0, 5'd14, 32'd5, 1);
    drain("remu0");
    run_op("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 1);
    drain("divovf");
    run_op("removf", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h0000_0000, 1);
    drain("removf");

    // Backpressure: result and tag held while out_ready is low.
    out_ready = 1'b0;
    run_op("hold", OP_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, DIV_LAT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_res", out_result, 32'd14);
      check("hold_rd", 32'(out_rd), 32'd17);
      check("hold_ovld", 32'(out_valid), 32'd1);
      check("hold_irdy", 32'(in_ready), 32'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    drain("hold");

    // Flush mid-BUSY discards the op.
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_DIVU; in_a = 32'd1000; in_b = 32'd3; in_rd = 5'd18;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_irdy", 32'(in_ready), 32'd1);
    check("flush_ovld", 32'(out_valid), 32'd0);
    rose = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (out_valid) rose = 1;
    end
    check("flush_never_valid", 32'(rose), 32'd0);
    run_op("postflush", OP_MUL, 32'd6, 32'd7, 5'd19, 32'd42, MUL_LAT);
    drain("postflush");

    // Async reset mid-BUSY returns straight to reset values.
    @(negedge clk);
    in_valid = 1'b1; in_op = OP_DIV; in_a = 32'd77; in_b = 32'd5; in_rd = 5'd20;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 nrst = 1'b0;
    #1;
    check("arst_irdy", 32'(in_ready), 32'd1);
    check("arst_ovld", 32'(out_valid), 32'd0);
    check("arst_res", out_result, 32'd0);
    check("arst_rd", 32'(out_rd), 32'd0);
    @(negedge clk); nrst = 1'b1;
    run_op("postrst", OP_REMU, 32'd100, 32'd7, 5'd21, 32'd2, DIV_LAT);
    drain("postrst");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
